// File: rtl/edge_pkg.sv
// Shared definitions for the edge_pulse_gen block: edge-select mode encodings
// and a constant-evaluable ceiling-log2 helper used to size internal counters.
// No ports; imported by edge_chan and edge_pulse_gen.
package edge_pkg;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    // Smallest r with 2**r >= n; returns at least 1 so it can size a vector.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/edge_chan.sv
// Purpose: one channel - input synchroniser, optional debounce, edge detect, retriggerable pulse.
// Latency: det_o true SYNC_STAGES-1 cycles after a_i is sampled; b_o rises one cycle later.
// Backpressure: none; a_i is sampled every cycle and pulses cannot be stalled.
//
// Ports: clk, rst (sync, active-high), a_i (async input), mode_i (edge select),
//        det_o (combinational edge detect), b_o (registered output pulse).
// Build option: EDGE_PULSE_GEN_DEBOUNCE_EN inserts a stable-cycle filter after the synchroniser.
module edge_chan
    import edge_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int PULSE_LEN       = 3,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_i,
    input  logic [1:0] mode_i,
    output logic       det_o,
    output logic       b_o
);

    localparam int CNT_BITS = clog2(PULSE_LEN + 1);
    localparam logic [CNT_BITS-1:0] LOAD = CNT_BITS'(PULSE_LEN);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [CNT_BITS-1:0]    cnt_q;
    logic [CNT_BITS-1:0]    cnt_d;
    logic                   b_q;
    logic                   s;
    logic                   filt;
    logic                   rise_en;
    logic                   fall_en;
    logic                   det;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], a_i};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

`ifdef EDGE_PULSE_GEN_DEBOUNCE_EN
    localparam int RUN_BITS = clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [RUN_BITS-1:0] RUN_LAST = RUN_BITS'(DEBOUNCE_CYCLES - 1);

    logic                filt_q;
    logic [RUN_BITS-1:0] run_q;

    // filt follows s only once s has disagreed with it for DEBOUNCE_CYCLES
    // consecutive cycles; any agreement restarts the run.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q <= 1'b0;
            run_q  <= '0;
        end else if (s != filt_q) begin
            if (run_q == RUN_LAST) begin
                filt_q <= s;
                run_q  <= '0;
            end else begin
                run_q <= run_q + 1'b1;
            end
        end else begin
            run_q <= '0;
        end
    end

    assign filt = filt_q;
`else
    logic unused_debounce;
    assign unused_debounce = (DEBOUNCE_CYCLES > 0);
    assign filt = s;
`endif

    // mode is live: a mode change alone never creates an edge because
    // detection only looks at the filt/prev_q pair.
    assign rise_en = (mode_i == MODE_RISE) || (mode_i == MODE_BOTH);
    assign fall_en = (mode_i == MODE_FALL) || (mode_i == MODE_BOTH);
    assign det     = (rise_en & filt & ~prev_q) | (fall_en & ~filt & prev_q);

    // A detect reloads the full length, so back-to-back edges merge gap-free.
    always_comb begin
        cnt_d = cnt_q;
        if (det) begin
            cnt_d = LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b0;
            cnt_q  <= '0;
            b_q    <= 1'b0;
        end else begin
            prev_q <= filt;
            cnt_q  <= cnt_d;
            b_q    <= (cnt_d != '0);
        end
    end

    assign det_o = det;
    assign b_o   = b_q;

endmodule

// File: rtl/edge_pulse_gen.sv
// Purpose: multi-channel edge-to-pulse front end with busy flag and saturating edge counter.
// Latency: b rises SYNC_STAGES cycles after an input edge is sampled; busy one cycle after b.
// Backpressure: none; every input edge within the selected mode is counted and pulsed.
//
// Ports: clk, rst (sync, active-high), a[WIDTH] (async inputs), mode (00 off/01 rise/10 fall/11 both),
//        clr_cnt (sync clear of edge_cnt), b[WIDTH] (pulses), busy (registered OR of b),
//        edge_cnt[CNT_W] (saturating total of detected edges).
// Build option: EDGE_PULSE_GEN_DEBOUNCE_EN enables the per-channel debounce filter.
module edge_pulse_gen
    import edge_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int PULSE_LEN       = 3,
    parameter int CNT_W           = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [1:0]       mode,
    input  logic             clr_cnt,
    output logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [CNT_W-1:0] edge_cnt
);

    localparam int PC_W  = clog2(WIDTH + 1);
    localparam int SUM_W = CNT_W + PC_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] det;
    logic [PC_W-1:0]  pc;
    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] edge_cnt_q;
    logic [CNT_W-1:0] edge_cnt_d;
    logic             busy_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        edge_chan #(
            .SYNC_STAGES    (SYNC_STAGES),
            .PULSE_LEN      (PULSE_LEN),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clk   (clk),
            .rst   (rst),
            .a_i   (a[i]),
            .mode_i(mode),
            .det_o (det[i]),
            .b_o   (b[i])
        );
    end

    always_comb begin
        pc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pc = pc + PC_W'(det[i]);
        end
    end

    // The sum is computed wide enough that it never wraps before the clamp.
    assign sum = SUM_W'(edge_cnt_q) + SUM_W'(pc);

    always_comb begin
        edge_cnt_d = sum[CNT_W-1:0];
        if (clr_cnt) begin
            edge_cnt_d = '0;
        end else if (sum > SUM_W'(CNT_MAX)) begin
            edge_cnt_d = CNT_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            edge_cnt_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            busy_q     <= |b;
        end
    end

    assign edge_cnt = edge_cnt_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_edge_pulse_gen.sv
module tb_edge_pulse_gen;
    import edge_pkg::*;

    typedef struct {
        logic       rst;
        logic [3:0] a;
        logic [1:0] mode;
        logic       clr;
        logic [3:0] b;
        logic       busy;
        logic [7:0] cnt;
        logic [1:0] cnt2;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr_cnt;
    logic [3:0] a;
    logic [1:0] mode;
    logic [3:0] b;
    logic [3:0] b2;
    logic       busy;
    logic       busy2;
    logic [7:0] edge_cnt;
    logic [1:0] edge_cnt2;

    int n_checks = 0;
    int n_fail   = 0;
    int step_idx = 0;

    vec_t tbl[$];
    vec_t sb_q[$];

    always #20 clk = ~clk;

    edge_pulse_gen #(
        .WIDTH(4), .SYNC_STAGES(2), .PULSE_LEN(3), .CNT_W(8), .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst), .a(a), .mode(mode), .clr_cnt(clr_cnt),
        .b(b), .busy(busy), .edge_cnt(edge_cnt)
    );

    // Narrow counter instance for saturation.
    edge_pulse_gen #(
        .WIDTH(4), .SYNC_STAGES(2), .PULSE_LEN(3), .CNT_W(2), .DEBOUNCE_CYCLES(4)
    ) dut_sat (
        .clk(clk), .rst(rst), .a(a), .mode(mode), .clr_cnt(clr_cnt),
        .b(b2), .busy(busy2), .edge_cnt(edge_cnt2)
    );

    function automatic vec_t mk(input logic r, input logic [3:0] ai, input logic [1:0] m,
                                input logic c, input logic [3:0] eb, input logic ebusy,
                                input logic [7:0] ec, input logic [1:0] ec2);
        vec_t v;
        v.rst = r; v.a = ai; v.mode = m; v.clr = c;
        v.b = eb; v.busy = ebusy; v.cnt = ec; v.cnt2 = ec2;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, pop and compare
    // once the DUT has registered the result (sampled on the falling edge).
    task automatic step(input vec_t v);
        vec_t e;
        rst     = v.rst;
        a       = v.a;
        mode    = v.mode;
        clr_cnt = v.clr;
        sb_q.push_back(v);
        @(posedge clk);
        @(negedge clk);
        e = sb_q.pop_front();
        check("b",         step_idx, 8'(b),     8'(e.b));
        check("busy",      step_idx, 8'(busy),  8'(e.busy));
        check("edge_cnt",  step_idx, edge_cnt,  e.cnt);
        check("b_sat",     step_idx, 8'(b2),    8'(e.b));
        check("busy_sat",  step_idx, 8'(busy2), 8'(e.busy));
        check("edge_cnt2", step_idx, 8'(edge_cnt2), 8'(e.cnt2));
        step_idx++;
    endtask

    initial begin
        rst = 1'b1; a = '0; mode = MODE_RISE; clr_cnt = 1'b0;

`ifdef EDGE_PULSE_GEN_DEBOUNCE_EN
        tbl.push_back(mk(1, 4'h0, MODE_RISE, 0, 4'h0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h0, MODE_RISE, 0, 4'h0, 0, 0, 0));
        // 3-cycle glitch: filtered out
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 4'h1, MODE_RISE, 0, 4'h0, 0, 0, 0));
        for (int i = 0; i < 7; i++) tbl.push_back(mk(0, 4'h0, MODE_RISE, 0, 4'h0, 0, 0, 0));
        // 6-cycle high: one pulse, 4 cycles later than undebounced
        for (int i = 0; i < 6; i++) tbl.push_back(mk(0, 4'h1, MODE_RISE, 0, 4'h0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h0, MODE_RISE, 0, 4'h1, 0, 1, 1));
        tbl.push_back(mk(0, 4'h0, MODE_RISE, 0, 4'h1, 1, 1, 1));
        tbl.push_back(mk(0, 4'h0, MODE_RISE, 0, 4'h1, 1, 1, 1));
        tbl.push_back(mk(0, 4'h0, MODE_RISE, 0, 4'h0, 1, 1, 1));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 4'h0, MODE_RISE, 0, 4'h0, 0, 1, 1));
        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);
`else
        // Reset, single rising edge on a[0], ignored falling edge
        tbl.push_back(mk(1, 4'h0, MODE_RISE, 0, 4'h0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h0, MODE_RISE, 0, 4'h0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h1, MODE_RISE, 0, 4'h0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h1, MODE_RISE, 0, 4'h0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h1, MODE_RISE, 0, 4'h1, 0, 1, 1));
        tbl.push_back(mk(0, 4'h1, MODE_RISE, 0, 4'h1, 1, 1, 1));
        tbl.push_back(mk(0, 4'h1, MODE_RISE, 0, 4'h1, 1, 1, 1));
        tbl.push_back(mk(0, 4'h1, MODE_RISE, 0, 4'h0, 1, 1, 1));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 4'h0, MODE_RISE, 0, 4'h0, 0, 1, 1));
        // Both edges on a[1], 5 cycles apart: two separate pulses
        tbl.push_back(mk(0, 4'h2, MODE_BOTH, 0, 4'h0, 0, 1, 1));
        tbl.push_back(mk(0, 4'h2, MODE_BOTH, 0, 4'h0, 0, 1, 1));
        tbl.push_back(mk(0, 4'h2, MODE_BOTH, 0, 4'h2, 0, 2, 2));
        tbl.push_back(mk(0, 4'h2, MODE_BOTH, 0, 4'h2, 1, 2, 2));
        tbl.push_back(mk(0, 4'h2, MODE_BOTH, 0, 4'h2, 1, 2, 2));
        tbl.push_back(mk(0, 4'h0, MODE_BOTH, 0, 4'h0, 1, 2, 2));
        tbl.push_back(mk(0, 4'h0, MODE_BOTH, 0, 4'h0, 0, 2, 2));
        tbl.push_back(mk(0, 4'h0, MODE_BOTH, 0, 4'h2, 0, 3, 3));
        tbl.push_back(mk(0, 4'h0, MODE_BOTH, 0, 4'h2, 1, 3, 3));
        tbl.push_back(mk(0, 4'h0, MODE_BOTH, 0, 4'h2, 1, 3, 3));
        tbl.push_back(mk(0, 4'h0, MODE_BOTH, 0, 4'h0, 1, 3, 3));
        tbl.push_back(mk(0, 4'h0, MODE_BOTH, 0, 4'h0, 0, 3, 3));
        // Clear, then edges 2 cycles apart: one merged 5-cycle pulse
        tbl.push_back(mk(0, 4'h2, MODE_BOTH, 1, 4'h0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h2, MODE_BOTH, 0, 4'h0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h0, MODE_BOTH, 0, 4'h2, 0, 1, 1));
        tbl.push_back(mk(0, 4'h0, MODE_BOTH, 0, 4'h2, 1, 1, 1));
        tbl.push_back(mk(0, 4'h0, MODE_BOTH, 0, 4'h2, 1, 2, 2));
        tbl.push_back(mk(0, 4'h0, MODE_BOTH, 0, 4'h2, 1, 2, 2));
        tbl.push_back(mk(0, 4'h0, MODE_BOTH, 0, 4'h2, 1, 2, 2));
        tbl.push_back(mk(0, 4'h0, MODE_BOTH, 0, 4'h0, 1, 2, 2));
        tbl.push_back(mk(0, 4'h0, MODE_BOTH, 0, 4'h0, 0, 2, 2));
        // All four channels rise together: +4, narrow counter saturates at 3
        tbl.push_back(mk(0, 4'hF, MODE_RISE, 0, 4'h0, 0, 2, 2));
        tbl.push_back(mk(0, 4'hF, MODE_RISE, 0, 4'h0, 0, 2, 2));
        tbl.push_back(mk(0, 4'hF, MODE_RISE, 0, 4'hF, 0, 6, 3));
        tbl.push_back(mk(0, 4'hF, MODE_RISE, 0, 4'hF, 1, 6, 3));
        tbl.push_back(mk(0, 4'hF, MODE_RISE, 0, 4'hF, 1, 6, 3));
        tbl.push_back(mk(0, 4'hF, MODE_RISE, 0, 4'h0, 1, 6, 3));
        tbl.push_back(mk(0, 4'hF, MODE_RISE, 0, 4'h0, 0, 6, 3));
        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // Reset mid-pulse, then a[0] held high through reset release
        for (int i = 0; i < 3; i++) step(mk(0, 4'h0, MODE_RISE, 0, 4'h0, 0, 6, 3));
        step(mk(0, 4'h1, MODE_RISE, 0, 4'h0, 0, 6, 3));
        step(mk(0, 4'h1, MODE_RISE, 0, 4'h0, 0, 6, 3));
        step(mk(0, 4'h1, MODE_RISE, 0, 4'h1, 0, 7, 3));
        step(mk(1, 4'h1, MODE_RISE, 0, 4'h0, 0, 0, 0));
        step(mk(0, 4'h1, MODE_RISE, 0, 4'h0, 0, 0, 0));
        step(mk(0, 4'h1, MODE_RISE, 0, 4'h0, 0, 0, 0));
        step(mk(0, 4'h1, MODE_RISE, 0, 4'h1, 0, 1, 1));
        step(mk(0, 4'h1, MODE_RISE, 0, 4'h1, 1, 1, 1));
        step(mk(0, 4'h1, MODE_RISE, 0, 4'h1, 1, 1, 1));
        step(mk(0, 4'h1, MODE_RISE, 0, 4'h0, 1, 1, 1));
        step(mk(0, 4'h1, MODE_RISE, 0, 4'h0, 0, 1, 1));
        step(mk(0, 4'h1, MODE_RISE, 0, 4'h0, 0, 1, 1));

        // clr_cnt in the same cycle as a detected edge: edge dropped, pulse kept
        step(mk(0, 4'h5, MODE_RISE, 0, 4'h0, 0, 1, 1));
        step(mk(0, 4'h5, MODE_RISE, 0, 4'h0, 0, 1, 1));
        step(mk(0, 4'h5, MODE_RISE, 1, 4'h4, 0, 0, 0));
        step(mk(0, 4'h5, MODE_RISE, 0, 4'h4, 1, 0, 0));
        step(mk(0, 4'h5, MODE_RISE, 0, 4'h4, 1, 0, 0));
        step(mk(0, 4'h5, MODE_RISE, 0, 4'h0, 1, 0, 0));
        step(mk(0, 4'h5, MODE_RISE, 0, 4'h0, 0, 0, 0));

        // mode=00 lets an in-flight pulse finish and ignores new edges;
        // switching to 11 with stable inputs creates nothing
        step(mk(0, 4'hD, MODE_RISE, 0, 4'h0, 0, 0, 0));
        step(mk(0, 4'hD, MODE_RISE, 0, 4'h0, 0, 0, 0));
        step(mk(0, 4'hD, MODE_RISE, 0, 4'h8, 0, 1, 1));
        step(mk(0, 4'h5, MODE_OFF,  0, 4'h8, 1, 1, 1));
        step(mk(0, 4'hD, MODE_OFF,  0, 4'h8, 1, 1, 1));
        step(mk(0, 4'h5, MODE_OFF,  0, 4'h0, 1, 1, 1));
        step(mk(0, 4'h5, MODE_OFF,  0, 4'h0, 0, 1, 1));
        step(mk(0, 4'h5, MODE_OFF,  0, 4'h0, 0, 1, 1));
        step(mk(0, 4'h5, MODE_BOTH, 0, 4'h0, 0, 1, 1));
        step(mk(0, 4'h5, MODE_BOTH, 0, 4'h0, 0, 1, 1));
`endif

        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
